pio_fifo: RTL and testbench

PIO_FIFO -- requirements
Module: pio_fifo

---
 rtl/pio_fifo_if.sv | 16 +
 rtl/pio_fifo.sv | 179 +++++++++++++++++
 tb/tb_pio_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pio_fifo_if.sv
// PC/CPU side bus of pio_fifo: PC nibble strobes plus CPU port read/write strobes.
interface pio_fifo_if #(parameter int PORT_W = 4);
    logic [3:0]        iPData;
    logic [4:0]        iCtrl;
    logic [7:0]        oPData;
    logic [PORT_W-1:0] iAddr;
    logic [15:0]       iData;
    logic              iREnb;
    logic              iWEnb;
    logic [15:0]       oData;

    modport master (output iPData, iCtrl, iAddr, iData, iREnb, iWEnb,
                    input  oPData, oData);
    modport slave  (input  iPData, iCtrl, iAddr, iData, iREnb, iWEnb,
                    output oPData, oData);
endinterface

// File: rtl/pio_fifo.sv
// Nibble-wide PC link bridged to a CPU port bus through two show-ahead FIFOs.
// Optional PIO_READ_ACK_EN: falling iCtrl[3] while Cmd==R_DATA acknowledges (pops) the output FIFO.
module pio_fifo_q #(
    parameter int DW = 12,
    parameter int AW = 2
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iClr,
    input  logic          iPush,
    input  logic          iPop,
    input  logic [DW-1:0] iDin,
    output logic [DW-1:0] oHead,
    output logic [AW:0]   oCount,
    output logic          oFull,
    output logic          oEmpty,
    output logic          oOvf
);
    localparam int N = 1 << AW;

    logic [DW-1:0] mem [N];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          doPop, doPush;

    assign oFull  = (cnt == (AW+1)'(N));
    assign oEmpty = (cnt == '0);
    // Pop is resolved first so a full FIFO can still accept a same-cycle push.
    assign doPop  = iPop & ~oEmpty;
    assign doPush = iPush & (~oFull | doPop);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (iClr) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPush && !doPop)      cnt <= cnt + (AW+1)'(1);
            else if (doPop && !doPush) cnt <= cnt - (AW+1)'(1);
            if (iPush && !doPush) ovf <= 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (doPush && !iClr) mem[wrPtr] <= iDin;
    end

    assign oHead  = oEmpty ? '0 : mem[rdPtr];
    assign oCount = cnt;
    assign oOvf   = ovf;
endmodule

module pio_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int PORT_W     = 4
) (
    input logic       iClk,
    input logic       iRst,
    pio_fifo_if.slave bus
);
    localparam logic [3:0] W_PORT = 4'h1;
    localparam logic [3:0] W_DATA = 4'h2;
    localparam logic [3:0] R_PORT = 4'h9;
    localparam logic [3:0] R_DATA = 4'hA;
    localparam logic [3:0] R_NEXT = 4'hB;
    localparam logic [3:0] R_STAT = 4'hC;
    localparam int EW = PORT_W + 8;

    logic              setCmd, setL, setH, clr;
    logic [3:0]        cmd, lowNib, highNib;
    logic [PORT_W-1:0] portIn;
    logic              wrHi, wrHiD, wrHiDD, nxtSig, nxtD, nxtDD;
    logic              inPush, outPop;

    logic [EW-1:0]       inHead, outHead;
    logic [DEPTH_LOG2:0] inCount, outCount;
    logic                inFull, inEmpty, inOvf, outFull, outEmpty, outOvf;
    logic [3:0]          inPortNib, outPortNib, outCntSat;
    logic [4:0]          outCnt5;
    logic [7:0]          unusedBits;

    assign setCmd = bus.iCtrl[1] & ~bus.iCtrl[0];
    assign setL   = bus.iCtrl[2] &  bus.iCtrl[0];
    assign setH   = bus.iCtrl[3] & ~bus.iCtrl[0];
    assign clr    = bus.iCtrl[4];
    assign wrHi   = (cmd == W_DATA) & setH;
    assign nxtSig = setCmd & (bus.iPData == R_NEXT);
    assign unusedBits = bus.iData[15:8];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cmd     <= '0;
            portIn  <= '0;
            lowNib  <= '0;
            highNib <= '0;
            wrHiD   <= 1'b0;
            wrHiDD  <= 1'b0;
            nxtD    <= 1'b0;
            nxtDD   <= 1'b0;
        end else begin
            if (setCmd) cmd <= bus.iPData;
            if (cmd == W_PORT && setL) portIn <= bus.iPData[PORT_W-1:0];
            if (clr) begin
                lowNib  <= '0;
                highNib <= '0;
            end else if (cmd == W_DATA) begin
                if (setL) lowNib  <= bus.iPData;
                if (setH) highNib <= bus.iPData;
            end
            wrHiD  <= wrHi;
            wrHiDD <= wrHiD;
            nxtD   <= nxtSig;
            nxtDD  <= nxtD;
        end
    end

    // Push lands one cycle after the high-nibble strobe, once the stage holds it.
    assign inPush = wrHiD & ~wrHiDD;

`ifdef PIO_READ_ACK_EN
    logic ackD, ackDD;
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ackD  <= 1'b0;
            ackDD <= 1'b0;
        end else begin
            ackD  <= bus.iCtrl[3];
            ackDD <= ackD;
        end
    end
    assign outPop = (nxtD & ~nxtDD) | (ackDD & ~ackD & (cmd == R_DATA));
`else
    assign outPop = nxtD & ~nxtDD;
`endif

    pio_fifo_q #(.DW(EW), .AW(DEPTH_LOG2)) uInQ (
        .iClk(iClk), .iRst(iRst), .iClr(clr),
        .iPush(inPush), .iPop(bus.iREnb),
        .iDin({portIn, highNib, lowNib}),
        .oHead(inHead), .oCount(inCount), .oFull(inFull), .oEmpty(inEmpty), .oOvf(inOvf)
    );

    pio_fifo_q #(.DW(EW), .AW(DEPTH_LOG2)) uOutQ (
        .iClk(iClk), .iRst(iRst), .iClr(clr),
        .iPush(bus.iWEnb), .iPop(outPop),
        .iDin({bus.iAddr, bus.iData[7:0]}),
        .oHead(outHead), .oCount(outCount), .oFull(outFull), .oEmpty(outEmpty), .oOvf(outOvf)
    );

    always_comb begin
        inPortNib  = '0;
        outPortNib = '0;
        inPortNib[PORT_W-1:0]  = inHead[EW-1:8];
        outPortNib[PORT_W-1:0] = outHead[EW-1:8];
        outCnt5    = 5'(outCount);
        outCntSat  = (outCnt5 > 5'd15) ? 4'hF : outCnt5[3:0];
    end

    assign bus.oData = {inEmpty, outFull, inOvf, outOvf, inPortNib, inHead[7:0]};

    always_comb begin
        bus.oPData = 8'h00;
        case (cmd)
            R_PORT:  bus.oPData = {outEmpty, outOvf, 2'b00, outPortNib};
            R_DATA:  bus.oPData = outHead[7:0];
            R_STAT:  bus.oPData = {inFull, inEmpty, outFull, outEmpty, outCntSat};
            default: bus.oPData = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_pio_fifo.sv
// Scoreboard bench for pio_fifo: stimulus queues expected oData/oPData, a negedge monitor checks.
module tb_pio_fifo;
    logic clk, rst;
    int   checks, failures;

    typedef struct {
        string       name;
        bit          isByte;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    pio_fifo_if #(.PORT_W(4)) bus ();
    pio_fifo #(.DEPTH_LOG2(2), .PORT_W(4)) dut (.iClk(clk), .iRst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs depend only on registers, so the negedge after queuing sees settled state.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = sb.pop_front();
            act = e.isByte ? {8'h00, bus.oPData} : bus.oData;
            checks++;
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expD(input string n, input logic [15:0] v);
        sb.push_back('{n, 1'b0, v});
    endtask

    task automatic expP(input string n, input logic [7:0] v);
        sb.push_back('{n, 1'b1, {8'h00, v}});
    endtask

    task automatic pcCmd(input logic [3:0] c);
        bus.iPData = c; bus.iCtrl = 5'b00010; tick(); bus.iCtrl = 5'b00000;
    endtask

    task automatic pcPort(input logic [3:0] p);
        pcCmd(4'h1);
        bus.iPData = p; bus.iCtrl = 5'b00101; tick(); bus.iCtrl = 5'b00000;
    endtask

    task automatic pcByte(input logic [7:0] b);
        pcCmd(4'h2);
        bus.iPData = b[3:0]; bus.iCtrl = 5'b00101; tick();
        bus.iPData = b[7:4]; bus.iCtrl = 5'b01000; tick();
        bus.iCtrl = 5'b00000; tick();
    endtask

    task automatic cpuWrite(input logic [3:0] a, input logic [7:0] d);
        bus.iAddr = a; bus.iData = {8'hEE, d}; bus.iWEnb = 1'b1; tick(); bus.iWEnb = 1'b0;
    endtask

    task automatic cpuRead();
        bus.iREnb = 1'b1; tick(); bus.iREnb = 1'b0;
    endtask

    task automatic rNext();
        pcCmd(4'hB); tick();
    endtask

    task automatic ackPulse();
        bus.iCtrl = 5'b01000; tick(); bus.iCtrl = 5'b00000; tick(); tick();
    endtask

    task automatic clearAll();
        bus.iCtrl = 5'b10000; tick(); bus.iCtrl = 5'b00000;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.iPData = '0; bus.iCtrl = '0; bus.iAddr = '0; bus.iData = '0;
        bus.iREnb = 1'b0; bus.iWEnb = 1'b0;
        tick();
        expD("reset_oData", 16'h8000);
        expP("reset_oPData", 8'h00);
        tick();
        rst = 1'b0;
        tick();
        pcCmd(4'hC); expP("reset_stat", 8'h50);

        // PC -> CPU transfer
        pcPort(4'h3);
        pcByte(8'hA5);
        pcByte(8'h3C);
        expD("in_head0", 16'h03A5);
        cpuRead(); expD("in_head1", 16'h033C);
        cpuRead(); expD("in_empty", 16'h8000);
        cpuRead(); expD("in_pop_empty", 16'h8000);

        // CPU -> PC overflow
        pcCmd(4'hC);
        for (int i = 1; i <= 4; i++) cpuWrite(4'(i), 8'(i * 17));
        expP("out_full_stat", 8'h64);
        expD("out_full_oData", 16'hC000);
        cpuWrite(4'h5, 8'h55);
        expD("out_ovf_oData", 16'hD000);
        expP("out_ovf_stat", 8'h64);
        clearAll();
        expD("clear_oData", 16'h8000);
        expP("clear_stat", 8'h50);

        // Full FIFO push and pop on one edge
        for (int i = 1; i <= 4; i++) cpuWrite(4'(i), 8'(i * 17));
        pcCmd(4'hB); expP("rnext_code", 8'h00);
        bus.iAddr = 4'h6; bus.iData = 16'h0066; bus.iWEnb = 1'b1; tick(); bus.iWEnb = 1'b0;
        pcCmd(4'hC); expP("pushpop_stat", 8'h64);
        expD("pushpop_noovf", 16'hC000);
        pcCmd(4'hA); expP("pushpop_head", 8'h22);
        pcCmd(4'h9); expP("pushpop_port", 8'h02);
        rNext(); pcCmd(4'hA); expP("next_33", 8'h33);
        rNext(); pcCmd(4'hA); expP("next_44", 8'h44);
        rNext(); pcCmd(4'hA); expP("tail_66", 8'h66);
        pcCmd(4'h9); expP("tail_port6", 8'h06);
        rNext(); pcCmd(4'hA); expP("out_empty_data", 8'h00);
        pcCmd(4'h9); expP("out_empty_port", 8'h80);

        // iCtrl[3] falling edges with Cmd=R_DATA
        cpuWrite(4'h7, 8'h77); cpuWrite(4'h8, 8'h88); cpuWrite(4'h9, 8'h99);
        pcCmd(4'hA); expP("ack_head", 8'h77);
`ifdef PIO_READ_ACK_EN
        ackPulse(); expP("ack_pulse1", 8'h88);
        ackPulse(); expP("ack_pulse2", 8'h99);
`else
        ackPulse(); expP("ack_pulse1", 8'h77);
        ackPulse(); expP("ack_pulse2", 8'h77);
        rNext(); pcCmd(4'hA); expP("ack_next1", 8'h88);
        rNext(); pcCmd(4'hA); expP("ack_next2", 8'h99);
`endif
        clearAll();

        // Clear against pending pushes on both sides
        for (int i = 1; i <= 5; i++) cpuWrite(4'(i), 8'(i));
        expD("pre_clear_ovf", 16'hD000);
        pcCmd(4'h2);
        bus.iPData = 4'h5; bus.iCtrl = 5'b00101; tick();
        bus.iPData = 4'h6; bus.iCtrl = 5'b01000; tick();
        bus.iCtrl = 5'b10000; bus.iAddr = 4'h2; bus.iData = 16'h0034; bus.iWEnb = 1'b1; tick();
        bus.iCtrl = 5'b00000; bus.iWEnb = 1'b0;
        expD("clear_wins_oData", 16'h8000);
        tick(); expD("clear_no_late_push", 16'h8000);
        pcCmd(4'hC); expP("clear_wins_stat", 8'h50);
        // Staged low nibble was cleared, PortIn kept
        pcCmd(4'h2);
        bus.iPData = 4'h7; bus.iCtrl = 5'b01000; tick(); bus.iCtrl = 5'b00000; tick();
        expD("stage_cleared", 16'h0370);

        // Input FIFO overflow
        pcByte(8'h01); pcByte(8'h02); pcByte(8'h03);
        pcCmd(4'hC); expP("in_full_stat", 8'h90);
        pcByte(8'h04);
        expD("in_ovf", 16'h2370);
        cpuRead(); expD("in_ovf_sticky", 16'h2301);
        clearAll();

        // Reset in the middle of a byte transfer
        pcCmd(4'h2);
        bus.iPData = 4'h1; bus.iCtrl = 5'b00101; tick();
        bus.iPData = 4'h2; bus.iCtrl = 5'b01000; tick();
        bus.iCtrl = 5'b00000;
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); expD("midreset_oData", 16'h8000);
        expP("midreset_oPData", 8'h00);
        tick(); expD("midreset_no_push", 16'h8000);

        tick(); tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
